// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: first-word-fall-through trace FIFO of writeback register writes with cycle timestamps.
module wb_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int TS_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trace_en,
  input  logic              trace_clear,
  input  logic              RegWrite_WB,
  input  logic [4:0]        Write_register_WB,
  input  logic [31:0]       Write_data_WB,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [4:0]        trace_reg,
  output logic [31:0]       trace_data,
  output logic [TS_W-1:0]   trace_ts,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic [7:0]        overflow_cnt
);
  localparam int EW = 5 + 32 + TS_W;
  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     head;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [TS_W-1:0]   ts_cnt;
  logic              cap, pop, push, drop;
  always_comb begin
    cap  = trace_en & RegWrite_WB & (Write_register_WB != 5'd0);
    pop  = trace_valid & trace_ready;
    push = cap & (~full | pop);
    drop = cap & full & ~pop;
    head = mem[rd_ptr];
  end
  assign full        = count == (ADDR_W+1)'(DEPTH);
  assign trace_valid = count != '0;
  // Storage is never reset, so the head is masked to keep an empty FIFO reading as zero.
  assign {trace_reg, trace_data, trace_ts} = trace_valid ? head : '0;
  always_ff @(posedge clk)
    if (reset_n && !trace_clear && push) mem[wr_ptr] <= {Write_register_WB, Write_data_WB, ts_cnt};
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ts_cnt       <= '0;
      overflow_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (trace_clear) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        overflow_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        if (drop && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
      end
    end
  end
endmodule
